axis_tg: RTL and testbench

Synthesizable AXI-Stream traffic generator that sits directly upstream of a NoC input port (`axis_in_*` of the butterfly or any other topology) and injects single-flit packets at a programmable offered load. Destinations are drawn uniformly at random, and each flit carries its generation timestamp and a per-destination sequence number so a downstream checker can measure latency and verify ordering. Per-destination and total sent counters feed the harness completion logic.

---
 rtl/axis_tg_pkg.sv | 28 ++
 rtl/axis_tg_queue.sv | 59 +++++
 rtl/axis_tg.sv | 178 +++++++++++++++++
 tb/tb_axis_tg.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tg_pkg.sv
// Shared types and helpers for the axis_tg traffic generator.
// Holds the LFSR constants and step function, the FSM state type and the
// default source-queue entry layout.
package axis_tg_pkg;

  localparam int unsigned LfsrWidth = 32;
  localparam logic [LfsrWidth-1:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } tg_state_e;

  // Entry layout for the default configuration (16 routers, 64-bit flits).
  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] ts;
    logic [31:0] seq;
  } tg_entry_t;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] cur);
    lfsr_next = {1'b0, cur[LfsrWidth-1:1]} ^ (cur[0] ? LfsrTaps : '0);
  endfunction

endpackage

// File: rtl/axis_tg_queue.sv
// First-word-fall-through source queue for axis_tg.
// The head entry is visible whenever the queue is non-empty; a pop on a full
// queue frees a slot in the same cycle so a simultaneous push is accepted.
module axis_tg_queue
  import axis_tg_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter type entry_t = tg_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t            mem [Depth];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(Depth));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/axis_tg.sv
// AXI-Stream traffic generator: injects single-flit packets at a programmable
// offered load towards uniformly random destinations. Each flit carries
// {generation ticks, per-destination sequence number}.
// Optional feature macro: AXIS_TG_DROP_COUNT_EN adds the dropped_packets output.
module axis_tg
  import axis_tg_pkg::*;
#(
  parameter logic [31:0] SEED        = 32'd1,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned TID         = 0,
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TID_WIDTH   = 4,
  parameter int unsigned NUM_ROUTERS = 16,
  parameter int unsigned QUEUE_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              load,
  input  logic [COUNT_WIDTH-1:0]   num_packets,
  input  logic                     start,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   sent_packets [NUM_ROUTERS],
  output logic [COUNT_WIDTH-1:0]   total_sent_packets,
`ifdef AXIS_TG_DROP_COUNT_EN
  output logic [COUNT_WIDTH-1:0]   dropped_packets,
`endif
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest
);

  localparam int unsigned HalfW      = TDATA_WIDTH / 2;
  localparam int unsigned RouterBits = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1;
  localparam int unsigned QCntW      = $clog2(QUEUE_DEPTH) + 1;
  // An all-zero LFSR would lock up.
  localparam logic [LfsrWidth-1:0] SeedInit = (SEED == '0) ? 32'd1 : SEED;

  typedef struct packed {
    logic [RouterBits-1:0] dest;
    logic [HalfW-1:0]      ts;
    logic [HalfW-1:0]      seq;
  } entry_t;

  tg_state_e              state_q, state_d;
  logic                   run, latch;
  logic [LfsrWidth-1:0]   lfsr_q;
  logic [COUNT_WIDTH-1:0] target_q;
  logic [COUNT_WIDTH-1:0] gen_total_q;
  logic [HalfW-1:0]       seq_cnt_q [NUM_ROUTERS];
  logic [COUNT_WIDTH-1:0] sent_q [NUM_ROUTERS];
  logic [COUNT_WIDTH-1:0] total_q;

  logic [RouterBits-1:0]  draw_dest;
  logic                   inject_evt, enq, deq;
  entry_t                 push_entry, head;
  logic                   q_empty, q_full;
  logic [QCntW-1:0]       q_count;

  assign draw_dest  = (NUM_ROUTERS > 1) ? lfsr_q[16 +: RouterBits] : '0;
  assign inject_evt = run && (gen_total_q != target_q) && (lfsr_q[15:0] < load);
  assign deq        = axis_out_tvalid && axis_out_tready;
  assign enq        = inject_evt && (!q_full || deq);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; DRAIN finishes on the cycle its last entry leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (gen_total_q == target_q) state_d = StDrain;
      StDrain: if (q_empty || (q_count == QCntW'(1) && deq)) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded controls.
  always_comb begin
    run   = (state_q == StRun);
    done  = (state_q == StDone);
    latch = (state_q == StIdle) && start;
  end

  // LFSR advances only while generating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      lfsr_q <= SeedInit;
    else if (run) lfsr_q <= lfsr_next(lfsr_q);
  end

  // Run target and count of successfully enqueued packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      gen_total_q <= '0;
    end else if (latch) begin
      target_q    <= num_packets;
      gen_total_q <= '0;
    end else if (enq) begin
      gen_total_q <= gen_total_q + COUNT_WIDTH'(1);
    end
  end

  // Per-destination sequence numbers advance only on accepted injections.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROUTERS; i++) seq_cnt_q[i] <= '0;
    end else if (enq) begin
      seq_cnt_q[draw_dest] <= seq_cnt_q[draw_dest] + HalfW'(1);
    end
  end

  // Build the entry for the current inject decision.
  always_comb begin
    push_entry      = '0;
    push_entry.dest = draw_dest;
    push_entry.ts   = ticks;
    push_entry.seq  = seq_cnt_q[draw_dest];
  end

  axis_tg_queue #(
    .Depth   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (push_entry),
    .pop       (deq),
    .head      (head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  // Handshake counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROUTERS; i++) sent_q[i] <= '0;
      total_q <= '0;
    end else if (deq) begin
      sent_q[head.dest] <= sent_q[head.dest] + COUNT_WIDTH'(1);
      total_q           <= total_q + COUNT_WIDTH'(1);
    end
  end

`ifdef AXIS_TG_DROP_COUNT_EN
  logic [COUNT_WIDTH-1:0] dropped_q;

  // Inject events lost to a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     dropped_q <= '0;
    else if (inject_evt && !enq) dropped_q <= dropped_q + COUNT_WIDTH'(1);
  end

  assign dropped_packets = dropped_q;
`endif

  assign sent_packets       = sent_q;
  assign total_sent_packets = total_q;

  // Payload is forced to zero while nothing is offered.
  assign axis_out_tvalid = !q_empty;
  assign axis_out_tdata  = axis_out_tvalid ? {head.ts, head.seq} : '0;
  assign axis_out_tdest  = axis_out_tvalid ? TDEST_WIDTH'(head.dest) : '0;
  assign axis_out_tlast  = axis_out_tvalid;
  assign axis_out_tid    = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_tg.sv
// Directed self-checking bench for axis_tg (default geometry, TID=5, SEED=1).
module tb_axis_tg;

  localparam int unsigned CntW   = 32;
  localparam int unsigned NumR   = 16;
  localparam int unsigned TidVal = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     load;
  logic [CntW-1:0] num_packets;
  logic            start;
  logic [31:0]     ticks = '0;
  logic            done;
  logic [CntW-1:0] sent_packets [NumR];
  logic [CntW-1:0] total_sent_packets;
`ifdef AXIS_TG_DROP_COUNT_EN
  logic [CntW-1:0] dropped_packets;
`endif
  logic            tvalid, tready, tlast;
  logic [63:0]     tdata;
  logic [3:0]      tid, tdest;

  int checks = 0;
  int failures = 0;

  // Expected destinations of injected flits (load=0xFFFF, from SEED=1).
  logic [3:0] exp_dest [1100];
  int inj40;

  axis_tg #(
    .SEED (32'd1),
    .TID  (TidVal)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load               (load),
    .num_packets        (num_packets),
    .start              (start),
    .ticks              (ticks),
    .done               (done),
    .sent_packets       (sent_packets),
    .total_sent_packets (total_sent_packets),
`ifdef AXIS_TG_DROP_COUNT_EN
    .dropped_packets    (dropped_packets),
`endif
    .axis_out_tvalid    (tvalid),
    .axis_out_tready    (tready),
    .axis_out_tdata     (tdata),
    .axis_out_tlast     (tlast),
    .axis_out_tid       (tid),
    .axis_out_tdest     (tdest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ticks <= ticks + 32'd1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint sum_sent();
    longint s = 0;
    for (int d = 0; d < NumR; d++) s += longint'(sent_packets[d]);
    return s;
  endfunction

  task automatic build_model();
    logic [31:0] s;
    int n;
    s = 32'd1;
    n = 0;
    inj40 = 0;
    for (int c = 0; n < 1100; c++) begin
      if (s[15:0] != 16'hFFFF) begin
        exp_dest[n] = s[19:16];
        n++;
        if (c < 40) inj40++;
      end
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b0;
    load = '0;
    num_packets = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b0;
    load = '0;
    num_packets = '0;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (tdata !== 64'd0) begin failures++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
    checks++;
    if (tdest !== 4'd0) begin failures++; $display("FAIL reset_tdest: got %0d expected 0", tdest); end
    checks++;
    if (total_sent_packets !== 32'd0) begin
      failures++; $display("FAIL reset_total: got %0d expected 0", total_sent_packets);
    end
    checks++;
    if (sum_sent() != 0) begin failures++; $display("FAIL reset_sent: got %0d expected 0", sum_sent()); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_packets();
    int seen_valid = 0;
    do_reset();
    load = 16'hFFFF;
    num_packets = 0;
    tready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (tvalid) seen_valid++;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++;
    if (seen_valid != 0) begin failures++; $display("FAIL zero_tvalid: got %0d expected 0", seen_valid); end
    checks++;
    if (total_sent_packets !== 32'd0) begin
      failures++; $display("FAIL zero_total: got %0d expected 0", total_sent_packets);
    end
  endtask

  task automatic test_load_zero();
    int seen_valid = 0;
    do_reset();
    load = 16'h0000;
    num_packets = 100;
    tready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tvalid) seen_valid++;
    end
    start = 1'b0;
    checks++;
    if (seen_valid != 0) begin failures++; $display("FAIL load0_tvalid: got %0d expected 0", seen_valid); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL load0_done: got %b expected 0", done); end
  endtask

  task automatic test_full_load();
    int n, cyc;
    int seq_exp [NumR];
    do_reset();
    for (int d = 0; d < NumR; d++) seq_exp[d] = 0;
    load = 16'hFFFF;
    num_packets = 100;
    tready = 1'b1;
    n = 0;
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 1000) begin
      if (tvalid) begin
        checks++;
        if (tdest !== exp_dest[n]) begin
          failures++; $display("FAIL full_dest[%0d]: got %0d expected %0d", n, tdest, exp_dest[n]);
        end
        checks++;
        if (tdata[31:0] !== 32'(seq_exp[tdest])) begin
          failures++; $display("FAIL full_seq[%0d]: got %0d expected %0d", n, tdata[31:0], seq_exp[tdest]);
        end
        checks++;
        if (tdata[63:32] !== ticks - 32'd1) begin
          failures++; $display("FAIL full_ts[%0d]: got %0d expected %0d", n, tdata[63:32], ticks - 32'd1);
        end
        seq_exp[tdest]++;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL full_done: got %b expected 1", done); end
    checks++;
    if (n != 100) begin failures++; $display("FAIL full_count: got %0d expected 100", n); end
    checks++;
    if (total_sent_packets !== 32'd100) begin
      failures++; $display("FAIL full_total: got %0d expected 100", total_sent_packets);
    end
    checks++;
    if (sum_sent() != 100) begin failures++; $display("FAIL full_sum: got %0d expected 100", sum_sent()); end
    for (int d = 0; d < NumR; d++) begin
      checks++;
      if (sent_packets[d] !== 32'(seq_exp[d])) begin
        failures++; $display("FAIL full_sent[%0d]: got %0d expected %0d", d, sent_packets[d], seq_exp[d]);
      end
    end
  endtask

  task automatic test_stall();
    int n, cyc, last_hs, bad_hold;
    int seq_exp [NumR];
    logic [31:0] t_run1;
    do_reset();
    for (int d = 0; d < NumR; d++) seq_exp[d] = 0;
    load = 16'hFFFF;
    num_packets = 100;
    tready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_run1 = ticks;
    bad_hold = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tvalid !== 1'b1 || tdata !== {t_run1, 32'd0} || tdest !== exp_dest[0]) begin
        if (bad_hold == 0)
          $display("FAIL stall_hold[%0d]: got v=%b d=%h dst=%0d expected v=1 d=%h dst=%0d",
                   i, tvalid, tdata, tdest, {t_run1, 32'd0}, exp_dest[0]);
        bad_hold++;
      end
    end
    checks++;
    if (bad_hold != 0) failures++;
`ifdef AXIS_TG_DROP_COUNT_EN
    checks++;
    if (dropped_packets !== 32'(inj40 - 16)) begin
      failures++; $display("FAIL stall_drops: got %0d expected %0d", dropped_packets, inj40 - 16);
    end
`endif
    checks++;
    if (total_sent_packets !== 32'd0) begin
      failures++; $display("FAIL stall_total0: got %0d expected 0", total_sent_packets);
    end
    tready = 1'b1;
    n = 0;
    cyc = 0;
    last_hs = -10;
    while (!done && cyc < 1000) begin
      if (tvalid) begin
        checks++;
        if (tdata[31:0] !== 32'(seq_exp[tdest])) begin
          failures++; $display("FAIL stall_seq[%0d]: got %0d expected %0d", n, tdata[31:0], seq_exp[tdest]);
        end
        seq_exp[tdest]++;
        n++;
        last_hs = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != last_hs + 1) begin
      failures++; $display("FAIL stall_done_lat: got done=%b at %0d expected 1 at %0d", done, cyc, last_hs + 1);
    end
    checks++;
    if (n != 100 || total_sent_packets !== 32'd100) begin
      failures++; $display("FAIL stall_total: got %0d/%0d expected 100", n, total_sent_packets);
    end
  endtask

  task automatic test_random_ready();
    int n, cyc;
    int seq_exp [NumR];
    logic [31:0] last_ts;
    do_reset();
    for (int d = 0; d < NumR; d++) seq_exp[d] = 0;
    load = 16'hFFFF;
    num_packets = 1000;
    n = 0;
    cyc = 0;
    last_ts = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 8000) begin
      tready = 1'($urandom_range(0, 1));
      if (tvalid && tready) begin
        checks++;
        if (tlast !== 1'b1 || tid !== 4'(TidVal)) begin
          failures++; $display("FAIL rnd_last_id[%0d]: got last=%b id=%0d expected 1/%0d", n, tlast, tid, TidVal);
        end
        checks++;
        if (tdata[63:32] < last_ts) begin
          failures++; $display("FAIL rnd_ts[%0d]: got %0d expected >= %0d", n, tdata[63:32], last_ts);
        end
        checks++;
        if (tdata[31:0] !== 32'(seq_exp[tdest])) begin
          failures++; $display("FAIL rnd_seq[%0d]: got %0d expected %0d", n, tdata[31:0], seq_exp[tdest]);
        end
        last_ts = tdata[63:32];
        seq_exp[tdest]++;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL rnd_done: got %b expected 1", done); end
    checks++;
    if (n != 1000 || total_sent_packets !== 32'd1000) begin
      failures++; $display("FAIL rnd_total: got %0d/%0d expected 1000", n, total_sent_packets);
    end
  endtask

  task automatic test_reset_drain();
    int n, cyc;
    int seq_exp [NumR];
    do_reset();
    load = 16'hFFFF;
    num_packets = 10;
    tready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdest !== exp_dest[k]) begin
        failures++; $display("FAIL drain_dest[%0d]: got v=%b %0d expected 1 %0d", k, tvalid, tdest, exp_dest[k]);
      end
      @(negedge clk);
    end
    tready = 1'b0;
    checks++;
    if (total_sent_packets !== 32'd3 || done !== 1'b0) begin
      failures++; $display("FAIL drain_pre: got total=%0d done=%b expected 3 0", total_sent_packets, done);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", tvalid); end
    checks++;
    if (total_sent_packets !== 32'd0 || sum_sent() != 0) begin
      failures++; $display("FAIL rst_counters: got %0d/%0d expected 0", total_sent_packets, sum_sent());
    end
    checks++;
    if (tdata !== 64'd0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_out: got tdata=%h done=%b expected 0 0", tdata, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NumR; d++) seq_exp[d] = 0;
    tready = 1'b1;
    n = 0;
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 200) begin
      if (tvalid) begin
        checks++;
        if (tdest !== exp_dest[n] || tdata[31:0] !== 32'(seq_exp[tdest]) ||
            tdata[63:32] !== ticks - 32'd1) begin
          failures++;
          $display("FAIL replay[%0d]: got dst=%0d seq=%0d ts=%0d expected %0d %0d %0d", n, tdest,
                   tdata[31:0], tdata[63:32], exp_dest[n], seq_exp[tdest], ticks - 32'd1);
        end
        seq_exp[tdest]++;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || total_sent_packets !== 32'd10) begin
      failures++; $display("FAIL replay_total: got done=%b total=%0d expected 1 10", done, total_sent_packets);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_zero_packets();
    test_load_zero();
    test_full_load();
    test_stall();
    test_random_ready();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
